// File: rtl/tdm_scan_sequencer_pkg.sv
// Shared constants and state type for the TDM scan sequencer.
package tdm_scan_sequencer_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/tdm_scan_sequencer_next_active_channel.sv
// Finds the next enabled channel above cur and the lowest enabled channel.
module next_active_channel
  import tdm_scan_sequencer_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  nxt,
  output logic              has_next,
  output logic [SEL_W-1:0]  first
);

  // Descending walk so the lowest qualifying bit wins.
  always_comb begin
    nxt      = cur;
    has_next = 1'b0;
    first    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (SEL_W'(i) > cur)) begin
        nxt      = SEL_W'(i);
        has_next = 1'b1;
      end
      if (mask[i]) begin
        first = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/tdm_scan_sequencer.sv
// Round-robin select generator for a 4:1 mux; assembles one frame per scan.
module tdm_scan_sequencer
  import tdm_scan_sequencer_pkg::*;
#(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] mask,
  input  logic              mux_y,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic [NUM_CH-1:0] frame,
  output logic              frame_valid
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              busy_q, busy_d;
  logic [NUM_CH-1:0] frame_q, frame_d;
  logic              fv_q, fv_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0] mask_q, mask_d;

  logic [SEL_W-1:0]  adv_nxt, adv_first;
  logic              adv_has;
  logic [SEL_W-1:0]  new_nxt, new_first;
  logic              new_has;
  logic              unused_nac;

  next_active_channel u_adv (
    .mask     (mask_q),
    .cur      (sel_q),
    .nxt      (adv_nxt),
    .has_next (adv_has),
    .first    (adv_first)
  );

  next_active_channel u_new (
    .mask     (mask),
    .cur      ('0),
    .nxt      (new_nxt),
    .has_next (new_has),
    .first    (new_first)
  );

  assign unused_nac = ^{adv_first, new_nxt, new_has};

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    frame_d  = frame_q;
    fv_d     = 1'b0;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    mask_d   = mask_q;
    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (en && (mask != '0)) begin
          mask_d   = mask;
          sel_d    = new_first;
          cnt_d    = '0;
          busy_d   = 1'b1;
          shadow_d = '0;
          state_d  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (cnt_q != LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          shadow_d[sel_q] = mux_y;
          cnt_d           = '0;
          if (adv_has) begin
            sel_d = adv_nxt;
          end else begin
            frame_d        = shadow_q;
            frame_d[sel_q] = mux_y;
            fv_d           = 1'b1;
            if (en && (mask != '0)) begin
              // Back-to-back frame: no idle cycle between scans.
              mask_d   = mask;
              sel_d    = new_first;
              shadow_d = '0;
            end else begin
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      frame_q  <= '0;
      fv_q     <= 1'b0;
      cnt_q    <= '0;
      shadow_q <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      frame_q  <= frame_d;
      fv_q     <= fv_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      mask_q   <= mask_d;
    end
  end

  assign sel         = sel_q;
  assign busy        = busy_q;
  assign frame       = frame_q;
  assign frame_valid = fv_q;

endmodule

// File: tb/tb_tdm_scan_sequencer.sv
// Random-stimulus bench: DWELL=4 and DWELL=1 instances vs. a frame-level model.
module tb_tdm_scan_sequencer;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] mask;
  logic [3:0] xv [2];

  logic       y_a, y_b;
  logic [1:0] sel_a, sel_b;
  logic       busy_a, busy_b;
  logic [3:0] frame_a, frame_b;
  logic       fv_a, fv_b;

  int n_chk;
  int n_pass;

  int         dw [2];
  logic       m_act [2];
  logic [3:0] m_mask [2];
  int         m_el [2];
  logic [3:0] m_acc [2];
  logic [3:0] m_frame [2];
  logic       m_fv [2];
  logic [1:0] m_sel [2];

  assign y_a = xv[0][sel_a];
  assign y_b = xv[1][sel_b];

  tdm_scan_sequencer #(.DWELL(4), .CNT_W(8)) u_d4 (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mask        (mask),
    .mux_y       (y_a),
    .sel         (sel_a),
    .busy        (busy_a),
    .frame       (frame_a),
    .frame_valid (fv_a)
  );

  tdm_scan_sequencer #(.DWELL(1), .CNT_W(8)) u_d1 (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mask        (mask),
    .mux_y       (y_b),
    .sel         (sel_b),
    .busy        (busy_b),
    .frame       (frame_b),
    .frame_valid (fv_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h exp %0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // j-th enabled channel (0-based) of mask m.
  function automatic logic [1:0] nth_set(input logic [3:0] m, input int j);
    int c;
    c = 0;
    nth_set = 2'd0;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) begin
        if (c == j) nth_set = 2'(b);
        c++;
      end
    end
  endfunction

  task automatic start_frame(input int i);
    m_act[i]  = 1'b1;
    m_mask[i] = mask;
    m_el[i]   = 0;
    m_acc[i]  = 4'h0;
    m_sel[i]  = nth_set(mask, 0);
  endtask

  // A frame of k channels lasts k*D cycles; cycle e visits channel e/D,
  // and the last cycle of each dwell samples that channel.
  task automatic model_edge(input int i);
    int         d;
    int         k;
    logic [1:0] ch;
    d = dw[i];
    if (rst) begin
      m_act[i]   = 1'b0;
      m_mask[i]  = 4'h0;
      m_el[i]    = 0;
      m_acc[i]   = 4'h0;
      m_frame[i] = 4'h0;
      m_fv[i]    = 1'b0;
      m_sel[i]   = 2'd0;
      return;
    end
    m_fv[i] = 1'b0;
    if (!m_act[i]) begin
      if (en && (mask != 4'h0)) start_frame(i);
    end else begin
      ch = nth_set(m_mask[i], m_el[i] / d);
      if ((m_el[i] % d) == d - 1) m_acc[i][ch] = xv[i][ch];
      k = $countones(m_mask[i]);
      if (m_el[i] == k * d - 1) begin
        m_frame[i] = m_acc[i];
        m_fv[i]    = 1'b1;
        if (en && (mask != 4'h0)) start_frame(i);
        else m_act[i] = 1'b0;
      end else begin
        m_el[i]++;
        m_sel[i] = nth_set(m_mask[i], m_el[i] / d);
      end
    end
  endtask

  task automatic check_all();
    chk("d4.sel",   {6'd0, sel_a},   {6'd0, m_sel[0]});
    chk("d4.busy",  {7'd0, busy_a},  {7'd0, m_act[0]});
    chk("d4.frame", {4'd0, frame_a}, {4'd0, m_frame[0]});
    chk("d4.fv",    {7'd0, fv_a},    {7'd0, m_fv[0]});
    chk("d1.sel",   {6'd0, sel_b},   {6'd0, m_sel[1]});
    chk("d1.busy",  {7'd0, busy_b},  {7'd0, m_act[1]});
    chk("d1.frame", {4'd0, frame_b}, {4'd0, m_frame[1]});
    chk("d1.fv",    {7'd0, fv_b},    {7'd0, m_fv[1]});
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    dw[0]  = 4;
    dw[1]  = 1;
    rst    = 1'b1;
    en     = 1'b0;
    mask   = 4'h0;
    xv[0]  = 4'hA;
    xv[1]  = 4'hA;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      model_edge(0);
      model_edge(1);
    end
    #1;
    check_all();

    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      rst = (c == 25) || (c == 26) || (c == 60) ||
            (c > 80 && $urandom_range(0, 70) == 0);
      if (c < 40) begin
        en   = (c == 0) || (c == 20);
        mask = 4'hF;
      end else if (c < 70) begin
        en   = 1'b1;
        mask = (c < 45) ? 4'h3 : 4'h8;
      end else if (c < 90) begin
        en   = 1'b1;
        mask = 4'h0;
      end else begin
        en   = ($urandom_range(0, 3) != 0);
        mask = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      end
      if (c >= 40 && $urandom_range(0, 2) == 0) begin
        xv[0] = 4'($urandom);
        xv[1] = 4'($urandom);
      end
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      check_all();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tdm_scan_sequencer.md
Name: tdm_scan_sequencer

Overview:
- Sequential front end for the 4:1 selector and 2:4 decoder stage. It generates the shared 2-bit select that drives both the mux select and the decoder select.
- It steps round-robin through the enabled channels, holding each one for DWELL cycles.
- At the end of each dwell it samples the mux output and assembles one 4-bit parallel frame per scan, marked by a one-cycle valid pulse.

Parameters:
- DWELL, 4, cycles the select is held on each active channel; legal range 1..255.
- CNT_W, 8, width of the dwell counter; must hold DWELL-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  scan enable; sampled only in IDLE and at frame end.
- mask  in  4  channel enable, bit i = channel i; latched at frame start.
- mux_y  in  1  output of the 4:1 selector for the current sel.
- sel  out  2  channel select; drives mux s[1:0] and decoder s[1:0].
- busy  out  1  high while a frame is in progress.
- frame  out  4  last completed frame; bit i = sample of channel i, 0 for masked-off channels.
- frame_valid  out  1  one-cycle pulse when frame updates.

Behaviour:
- Reset (rst=1 at a clk edge, any state): state=IDLE, sel=0, busy=0, frame=0, frame_valid=0, cnt=0, shadow=0, mask_q=0. Reset mid-frame aborts the frame with no frame_valid, and frame returns to 0.
- States are IDLE and SCAN. sel is registered and is never X.
- IDLE, en=1 and mask!=0 at an edge:
  - mask_q<=mask; sel<=lowest set bit of mask; cnt<=0; busy<=1; shadow<=0; go to SCAN.
- IDLE, en=0 or mask==0: hold. sel keeps its last value, busy=0.
- SCAN, each edge with cnt<DWELL-1: cnt<=cnt+1; sel is held.
- SCAN, edge with cnt==DWELL-1 (sample edge):
  - shadow[sel]<=mux_y; cnt<=0.
  - If a higher set bit exists in mask_q: sel<=that bit (skipped channels take zero cycles).
  - Otherwise the frame ends:
    - frame<=shadow with bit sel replaced by mux_y; frame_valid<=1 for exactly this next cycle.
    - If en=1 and mask!=0: immediately restart with mask_q<=mask, sel<=lowest set bit, busy stays 1, shadow<=0. There is no idle gap.
    - Otherwise: go to IDLE, busy<=0.
- Latency: for k active channels, frame_valid appears k*DWELL edges after the edge that left IDLE.
- Changes to mask mid-frame are ignored until the next frame start.
- Dropping en mid-frame does not abort; the frame completes.
- DWELL=1 samples on every edge.
- Single active channel: sel is constant, and frame_valid pulses every DWELL cycles while en=1.
- Only the current sel bit is sampled, because the mux is combinational and sel has been stable the full dwell.

Decomposition:
- Shared package:
  - NUM_CH=4, SEL_W=2.
  - State encoding constants ST_IDLE=0, ST_SCAN=1.
- One combinational sub-module, next_active_channel:
  - Inputs: mask[3:0], cur[1:0].
  - Outputs: nxt[1:0] (next set bit above cur), has_next (1 if one exists), first[1:0] (lowest set bit of mask).
  - Used both for the advance step and for the restart.

Test Plan:
- Reset: assert rst for 2 edges mid-scan (DWELL=4, mask=1111) -> next cycle sel=0, busy=0, frame=0, frame_valid=0, no pulse afterward with en=0.
- Full scan: DWELL=4, mask=1111, mux inputs x=1010, en=1 for one edge then 0 -> sel=0,1,2,3 each held 4 cycles; frame_valid single pulse 16 edges after start, frame=1010; then busy=0, IDLE.
- Masked scan: mask=1010, x=1111, DWELL=2 -> sel visits only 1 then 3, 2 cycles each; frame_valid at edge 4; frame=1010.
- Continuous + mask change: en held 1, mask=0011 then changed to 1000 mid-frame -> first frame still covers channels 0,1 (pulse at edge 8); next frame starts with no gap at sel=3; pulse 4 edges later.
- Edge cases: mask=0000 with en=1 -> stays IDLE, busy=0. DWELL=1 with mask=0100 -> sel=2 constant, frame_valid high every cycle, frame=x[2]<<2 tracking x each cycle.
- Reset mid-frame: rst one edge at cnt=2 of channel 1 -> no frame_valid; with en=1, a new scan starts cleanly at lowest mask bit on the first edge after rst releases.
